// File: rtl/vrased_reset_ctrl.sv
// Collects monitor violation resets into one stretched CPU reset, with sticky
// cause/count/retry records and a release sequence tolerant of boot-time KILL residue.
module vrased_reset_ctrl #(
  parameter int N_SRC       = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int WAIT_MAX    = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] viol,
  output logic             sys_rst,
  output logic [N_SRC-1:0] cause,
  output logic [7:0]       viol_cnt,
  output logic             retry_err
);

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] WAIT_LD = 8'(WAIT_MAX - 1);

  state_e           state_q;
  logic [7:0]       cnt_q;
  logic             sys_rst_q;
  logic [N_SRC-1:0] cause_q;
  logic [7:0]       viol_cnt_q;
  logic             retry_err_q;

  logic [N_SRC-1:0] cause_d;
  logic [7:0]       viol_cnt_d;
  logic             viol_any;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    viol_any   = |viol;
    cause_d    = cause_q | viol;
    viol_cnt_d = sat_inc(viol_cnt_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= HOLD;
      cnt_q       <= HOLD_LD;
      sys_rst_q   <= 1'b1;
      cause_q     <= '0;
      viol_cnt_q  <= 8'd0;
      retry_err_q <= 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          // Residue from monitors still in KILL is recorded but never counted.
          cause_q <= cause_d;
          if (cnt_q == 8'd0) begin
            state_q   <= WAIT;
            cnt_q     <= WAIT_LD;
            sys_rst_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        WAIT: begin
          cause_q <= cause_d;
          if (!viol_any) begin
            state_q <= RUN;
          end else if (cnt_q == 8'd0) begin
            state_q     <= HOLD;
            cnt_q       <= HOLD_LD;
            sys_rst_q   <= 1'b1;
            retry_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        RUN: begin
          if (viol_any) begin
            state_q    <= HOLD;
            cnt_q      <= HOLD_LD;
            sys_rst_q  <= 1'b1;
            cause_q    <= cause_d;
            viol_cnt_q <= viol_cnt_d;
          end
        end
        default: begin
          state_q   <= HOLD;
          cnt_q     <= HOLD_LD;
          sys_rst_q <= 1'b1;
        end
      endcase
    end
  end

  assign sys_rst   = sys_rst_q;
  assign cause     = cause_q;
  assign viol_cnt  = viol_cnt_q;
  assign retry_err = retry_err_q;

endmodule

// File: tb/tb_vrased_reset_ctrl.sv
// Directed bench for vrased_reset_ctrl: expected outputs are queued per step
// and compared against the DUT after each clock edge.
module tb_vrased_reset_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] viol;
  logic       sys_rst;
  logic [3:0] cause;
  logic [7:0] viol_cnt;
  logic       retry_err;

  vrased_reset_ctrl #(
    .N_SRC      (4),
    .HOLD_CYCLES(16),
    .WAIT_MAX   (64)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .viol     (viol),
    .sys_rst  (sys_rst),
    .cause    (cause),
    .viol_cnt (viol_cnt),
    .retry_err(retry_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       sr;
    logic [3:0] cause;
    logic [7:0] cnt;
    logic       rerr;
  } exp_t;

  exp_t sb[$];
  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [3:0] e_cause;
  logic [7:0] e_cnt;
  logic       e_rerr;

  task automatic push(input string tag, input logic sr);
    exp_t e;
    e.tag   = tag;
    e.sr    = sr;
    e.cause = e_cause;
    e.cnt   = e_cnt;
    e.rerr  = e_rerr;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    e = sb.pop_front();
    n_total++;
    assert (sys_rst === e.sr) n_pass++;
    else begin n_fail++; $error("FAIL %s sys_rst: got %b expected %b", e.tag, sys_rst, e.sr); end
    n_total++;
    assert (cause === e.cause) n_pass++;
    else begin n_fail++; $error("FAIL %s cause: got %b expected %b", e.tag, cause, e.cause); end
    n_total++;
    assert (viol_cnt === e.cnt) n_pass++;
    else begin n_fail++; $error("FAIL %s viol_cnt: got %0d expected %0d", e.tag, viol_cnt, e.cnt); end
    n_total++;
    assert (retry_err === e.rerr) n_pass++;
    else begin n_fail++; $error("FAIL %s retry_err: got %b expected %b", e.tag, retry_err, e.rerr); end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_now(input string tag, input logic sr);
    push(tag, sr);
    pop_check();
  endtask

  task automatic run(input string tag, input int n, input logic sr);
    for (int i = 0; i < n; i++) begin
      push(tag, sr);
      cyc();
      pop_check();
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    e_cause = 4'b0000;
    e_cnt   = 8'd0;
    e_rerr  = 1'b0;
    check_now("reset_async", 1'b1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_now("reset_state", 1'b1);
  endtask

  task automatic por_to_run();
    viol = 4'b0000;
    apply_reset();
    run("por_hold", 15, 1'b1);
    run("por_release", 1, 1'b0);
    run("por_run", 3, 1'b0);
  endtask

  initial begin
    reset   = 1'b1;
    viol    = 4'b0000;
    e_cause = 4'b0000;
    e_cnt   = 8'd0;
    e_rerr  = 1'b0;

    // Power-on: 16 cycles of reset after deassert, then release and RUN.
    por_to_run();

    // Boot residue: viol[0] held through HOLD and 5 cycles into WAIT.
    viol = 4'b0000;
    apply_reset();
    viol    = 4'b0001;
    e_cause = 4'b0001;
    run("boot_hold", 15, 1'b1);
    run("boot_wait", 6, 1'b0);
    viol = 4'b0000;
    run("boot_run", 5, 1'b0);

    // Single DMA violation pulse in RUN.
    por_to_run();
    viol    = 4'b0001;
    e_cause = 4'b0001;
    e_cnt   = 8'd1;
    run("dma_hit", 1, 1'b1);
    viol = 4'b0000;
    run("dma_hold", 15, 1'b1);
    run("dma_release", 2, 1'b0);

    // Two sources in the same RUN cycle count once.
    viol    = 4'b0101;
    e_cause = 4'b0101;
    e_cnt   = 8'd2;
    run("simul_hit", 1, 1'b1);
    viol = 4'b0000;
    run("simul_hold", 15, 1'b1);
    run("simul_release", 3, 1'b0);

    // Persistent viol[2]: repeated HOLD/WAIT cycles with retry_err.
    viol = 4'b0000;
    apply_reset();
    viol    = 4'b0100;
    e_cause = 4'b0100;
    run("to_hold1", 15, 1'b1);
    run("to_wait1", 64, 1'b0);
    e_rerr = 1'b1;
    run("to_hold2", 16, 1'b1);
    run("to_wait2", 64, 1'b0);
    run("to_hold3", 2, 1'b1);

    // Saturation: 300 separated violations.
    por_to_run();
    for (int i = 0; i < 300; i++) begin
      viol    = 4'b0001;
      e_cause = 4'b0001;
      if (i < 255) e_cnt = 8'(i + 1);
      run("sat_hit", 1, 1'b1);
      viol = 4'b0000;
      run("sat_hold", 15, 1'b1);
      run("sat_release", 2, 1'b0);
    end
    e_cnt = 8'd255;
    check_now("sat_final", 1'b0);

    // Async reset in the middle of HOLD clears everything and restarts the hold.
    viol = 4'b0001;
    run("sat_301", 1, 1'b1);
    viol = 4'b0000;
    run("mid_hold", 5, 1'b1);
    reset = 1'b1;
    #1;
    e_cause = 4'b0000;
    e_cnt   = 8'd0;
    e_rerr  = 1'b0;
    check_now("async_clear", 1'b1);
    run("reset_held", 2, 1'b1);
    reset = 1'b0;
    check_now("rehold_start", 1'b1);
    run("rehold", 15, 1'b1);
    run("rehold_release", 3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
